// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state encoding and default WS2812 timing (clk cycles at 50 MHz)
package ws2812_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_e;
    localparam int T0H_DEF  = 20;
    localparam int T1H_DEF  = 40;
    localparam int TBIT_DEF = 63;
    localparam int TRES_DEF = 3000;
endpackage

// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: one bit period, high for T0H/T1H cycles then low until TBIT cycles
module ws2812_bit_enc
    import ws2812_pkg::*;
#(
    parameter int T0H  = T0H_DEF,
    parameter int T1H  = T1H_DEF,
    parameter int TBIT = TBIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic go_i,
    input  logic bit_i,
    output logic dout_o,
    output logic bit_done_o
);
    localparam int CW = $clog2(TBIT);
    logic [CW-1:0] cnt_q, cnt_d, th;
    logic          active_q, bit_q, dout_q;
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        th    = bit_q ? CW'(T1H) : CW'(T0H);
    end
    assign bit_done_o = active_q && cnt_q == CW'(TBIT - 1);
    assign dout_o     = dout_q;
    // go wins over bit_done so the next bit starts in the cycle right after the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else if (go_i) begin
            cnt_q    <= '0;
            active_q <= 1'b1;
            bit_q    <= bit_i;
            dout_q   <= 1'b1;
        end else if (bit_done_o) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            dout_q   <= 1'b0;
        end else if (active_q) begin
            cnt_q  <= cnt_d;
            dout_q <= cnt_d < th;
        end
    end
endmodule

// File: rtl/ws2812_scanner.sv
// ws2812_scanner: streams NPIX GRB words from a frame RAM to a WS2812 chain, then latches
module ws2812_scanner
    import ws2812_pkg::*;
#(
    parameter int AW   = 6,
    parameter int DW   = 24,
    parameter int NPIX = 64,
    parameter int T0H  = T0H_DEF,
    parameter int T1H  = T1H_DEF,
    parameter int TBIT = TBIT_DEF,
    parameter int TRES = TRES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] addr_out,
    output logic          rd,
    input  logic [DW-1:0] data_in,
    output logic          dout,
    output logic          busy,
    output logic          frame_done
);
    localparam int BW = $clog2(DW);
    localparam int LW = $clog2(TRES);
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [DW-2:0] sreg_q;
    logic [DW-1:0] pre_q;
    logic [BW-1:0] bcnt_q;
    logic [LW-1:0] lcnt_q;
    logic          rd_q, cap_q, pre_v_q, busy_q, done_q;
    logic          bit_done, go, go_bit, pix_end;
    // the next bit is handed to the encoder in the last cycle of the current one
    always_comb begin
        pix_end = bcnt_q == '0;
        go      = state_q == LOAD || (state_q == SEND && bit_done && (!pix_end || pre_v_q));
        go_bit  = state_q == LOAD ? data_in[DW-1] : pix_end ? pre_q[DW-1] : sreg_q[DW-2];
    end
    ws2812_bit_enc #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_enc (
        .clk       (clk),
        .rst       (rst),
        .go_i      (go),
        .bit_i     (go_bit),
        .dout_o    (dout),
        .bit_done_o(bit_done)
    );
    assign addr_out   = addr_q;
    assign rd         = rd_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sreg_q  <= '0;
            pre_q   <= '0;
            bcnt_q  <= '0;
            lcnt_q  <= '0;
            rd_q    <= 1'b0;
            cap_q   <= 1'b0;
            pre_v_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            cap_q  <= rd_q && state_q == SEND;
            if (cap_q) pre_q <= data_in;
            case (state_q)
                IDLE: if (start && !done_q) begin
                    state_q <= FETCH;
                    busy_q  <= 1'b1;
                    rd_q    <= 1'b1;
                    addr_q  <= '0;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    sreg_q  <= data_in[DW-2:0];
                    bcnt_q  <= BW'(DW - 1);
                    state_q <= SEND;
                    pre_v_q <= addr_q != LAST;
                    if (addr_q != LAST) begin
                        rd_q   <= 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                SEND: if (bit_done) begin
                    if (!pix_end) begin
                        sreg_q <= {sreg_q[DW-3:0], 1'b0};
                        bcnt_q <= bcnt_q - 1'b1;
                    end else if (pre_v_q) begin
                        sreg_q  <= pre_q[DW-2:0];
                        bcnt_q  <= BW'(DW - 1);
                        pre_v_q <= addr_q != LAST;
                        if (addr_q != LAST) begin
                            rd_q   <= 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end else begin
                        state_q <= LATCH;
                        lcnt_q  <= '0;
                    end
                end
                LATCH: if (lcnt_q == LW'(TRES - 1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    addr_q  <= '0;
                end else begin
                    lcnt_q <= lcnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_scanner.sv
// tb_ws2812_scanner: scoreboard bench decoding the serial line of a 2-pixel and a 64-pixel scanner
module tb_ws2812_scanner;
    localparam int A_T0H = 20, A_T1H = 40, A_TBIT = 63, A_TRES = 3000;
    localparam int B_T0H = 2, B_T1H = 5, B_TBIT = 9, B_TRES = 25;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [5:0]  addr_a, addr_b, addr_s;
    logic        rd_a, rd_b, dout_a, dout_b, busy_a, busy_b, done_a, done_b;
    logic        dout_s, rd_s, busy_s, done_s;
    logic [23:0] din_a, din_b;
    logic [23:0] ram_a [64];
    logic [23:0] ram_b [64];
    int          n_checks = 0, n_pass = 0;
    bit          exp_bits[$];
    int          exp_addr[$];
    int          rise_q[$], width_q[$], rda_q[$], rdk_q[$], done_q[$];
    bit          busy_h[$];

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (rd_a) din_a <= ram_a[addr_a];
        if (rd_b) din_b <= ram_b[addr_b];
    end
    assign dout_s = sel ? dout_b : dout_a;
    assign rd_s   = sel ? rd_b : rd_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign addr_s = sel ? addr_b : addr_a;

    ws2812_scanner #(.NPIX(2), .T0H(A_T0H), .T1H(A_T1H), .TBIT(A_TBIT), .TRES(A_TRES)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .addr_out(addr_a), .rd(rd_a), .data_in(din_a),
        .dout(dout_a), .busy(busy_a), .frame_done(done_a));
    ws2812_scanner #(.NPIX(64), .T0H(B_T0H), .T1H(B_T1H), .TBIT(B_TBIT), .TRES(B_TRES)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .addr_out(addr_b), .rd(rd_b), .data_in(din_b),
        .dout(dout_b), .busy(busy_b), .frame_done(done_b));

    task automatic drive_start(input bit v);
        if (sel) start_b = v;
        else start_a = v;
    endtask

    task automatic push_frame(input int npix);
        logic [23:0] w;
        exp_bits.delete();
        exp_addr.delete();
        for (int p = 0; p < npix; p++) begin
            w = sel ? ram_b[p] : ram_a[p];
            exp_addr.push_back(p);
            for (int b = 23; b >= 0; b--) exp_bits.push_back(w[b]);
        end
    endtask

    // k counts cycles after the edge that samples start; k=1 is the first cycle after it
    task automatic capture(input int max_k, input int inj_k, input bit inj_done);
        bit prev;
        int hi, stop;
        prev = 1'b0;
        hi = 0;
        stop = 0;
        rise_q.delete(); width_q.delete(); rda_q.delete(); rdk_q.delete(); done_q.delete(); busy_h.delete();
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            drive_start(1'b0);
            busy_h.push_back(busy_s);
            if (rd_s) begin
                rda_q.push_back(int'(addr_s));
                rdk_q.push_back(k);
            end
            if (dout_s && !prev) rise_q.push_back(k);
            if (dout_s) hi++;
            else if (prev) begin
                width_q.push_back(hi);
                hi = 0;
            end
            prev = dout_s;
            if (done_s) begin
                done_q.push_back(k);
                if (stop == 0) stop = k + 20;
                if (inj_done) drive_start(1'b1);
            end
            if (k == inj_k) drive_start(1'b1);
            if (k == stop) break;
        end
    endtask

    task automatic test_reset();
        int highs;
        highs = 0;
        sel = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dout_a, rd_a, busy_a, done_a} !== 4'b0 || addr_a !== 6'd0)
            $display("FAIL reset_state: dout=%b rd=%b busy=%b done=%b addr=%0d, want all 0", dout_a, rd_a, busy_a, done_a, addr_a);
        else n_pass++;
        rst = 1'b0;
        ram_a[0] = 24'hFF0000;
        ram_a[1] = 24'h000000;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 100 && !dout_a; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_checks++;
        if (dout_a !== 1'b1) $display("FAIL reset_midbit_setup: dout=%b, want 1", dout_a);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dout_a !== 1'b0) $display("FAIL reset_async_dout: dout=%b, want 0", dout_a);
        else n_pass++;
        @(negedge clk) rst = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || addr_a !== 6'd0) $display("FAIL reset_release: busy=%b addr=%0d, want 0/0", busy_a, addr_a);
        else n_pass++;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (dout_a || rd_a) highs++;
        end
        n_checks++;
        if (highs !== 0) $display("FAIL reset_quiet: %0d cycles with dout/rd high, want 0", highs);
        else n_pass++;
    endtask

    task automatic test_pattern();
        int bad, i, w, last;
        bit b;
        bad = 0;
        i = 0;
        sel = 1'b0;
        ram_a[0] = 24'hFF0000;
        ram_a[1] = 24'h000000;
        @(negedge clk) drive_start(1'b1);
        push_frame(2);
        capture(8000, 0, 1'b0);
        n_checks++;
        if (width_q.size() !== 48) $display("FAIL pattern_pulses: %0d pulses, want 48", width_q.size());
        else n_pass++;
        while (exp_bits.size() > 0 && width_q.size() > 0) begin
            b = exp_bits.pop_front();
            w = width_q.pop_front();
            n_checks++;
            if (w !== (b ? A_T1H : A_T0H)) $display("FAIL pattern_width: bit %0d high %0d cycles, want %0d", i, w, b ? A_T1H : A_T0H);
            else n_pass++;
            i++;
        end
        for (int j = 1; j < rise_q.size(); j++) if (rise_q[j] - rise_q[j-1] != A_TBIT) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL pattern_period: %0d periods not %0d cycles, want 0", bad, A_TBIT);
        else n_pass++;
        last = rise_q.size() > 0 ? rise_q[rise_q.size()-1] : 0;
        n_checks++;
        if (done_q.size() !== 1 || done_q[0] !== last + A_TBIT + A_TRES)
            $display("FAIL pattern_latch: %0d done pulses at %0d, want 1 at %0d", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, last + A_TBIT + A_TRES);
        else n_pass++;
        while (exp_addr.size() > 0 && rda_q.size() > 0) begin
            w = exp_addr.pop_front();
            i = rda_q.pop_front();
            n_checks++;
            if (i !== w) $display("FAIL pattern_addr: rd at %0d, want %0d", i, w);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        int bad, w;
        bit b;
        bad = 0;
        sel = 1'b0;
        ram_a[0] = 24'($urandom);
        ram_a[1] = 24'($urandom);
        @(negedge clk) drive_start(1'b1);
        push_frame(2);
        capture(8000, 0, 1'b0);
        n_checks++;
        if ((rdk_q.size() > 0 ? rdk_q[0] : -1) !== 1) $display("FAIL latency_rd: first rd at %0d, want 1", rdk_q.size() > 0 ? rdk_q[0] : -1);
        else n_pass++;
        n_checks++;
        if ((rise_q.size() > 0 ? rise_q[0] : -1) !== 3) $display("FAIL latency_dout: first rise at %0d, want 3", rise_q.size() > 0 ? rise_q[0] : -1);
        else n_pass++;
        n_checks++;
        if ((rdk_q.size() > 1 ? rdk_q[1] : -1) !== 3) $display("FAIL latency_prefetch: second rd at %0d, want 3", rdk_q.size() > 1 ? rdk_q[1] : -1);
        else n_pass++;
        n_checks++;
        if (width_q.size() !== 48) $display("FAIL latency_pulses: %0d pulses, want 48", width_q.size());
        else n_pass++;
        while (exp_bits.size() > 0 && width_q.size() > 0) begin
            b = exp_bits.pop_front();
            w = width_q.pop_front();
            if (w != (b ? A_T1H : A_T0H)) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL latency_data: %0d bits decoded wrong, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int d, extra;
        extra = 0;
        sel = 1'b0;
        ram_a[0] = 24'($urandom);
        ram_a[1] = 24'($urandom);
        @(negedge clk) drive_start(1'b1);
        push_frame(2);
        capture(8000, 500, 1'b1);
        d = done_q.size() > 0 ? done_q[0] : 2;
        n_checks++;
        if (done_q.size() !== 1) $display("FAIL ignore_done: %0d done pulses, want 1", done_q.size());
        else n_pass++;
        n_checks++;
        if (rda_q.size() !== 2) $display("FAIL ignore_rd: %0d rd pulses, want 2", rda_q.size());
        else n_pass++;
        n_checks++;
        if (rise_q.size() !== 48) $display("FAIL ignore_pulses: %0d pulses, want 48", rise_q.size());
        else n_pass++;
        n_checks++;
        if (busy_h[d-2] !== 1'b1 || busy_h[d] !== 1'b0) $display("FAIL ignore_busy: busy before/after done %b/%b, want 1/0", busy_h[d-2], busy_h[d]);
        else n_pass++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy_a || dout_a || rd_a) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL ignore_idle: %0d active cycles after frame, want 0", extra);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        ram_a[0] = 24'h000001;
        ram_a[1] = 24'h800000;
        @(negedge clk) drive_start(1'b1);
        push_frame(2);
        capture(8000, 0, 1'b0);
        n_checks++;
        if (width_q.size() !== 48) $display("FAIL boundary_pulses: %0d pulses, want 48", width_q.size());
        else n_pass++;
        if (width_q.size() >= 48) begin
            n_checks++;
            if (width_q[22] !== A_T0H || width_q[23] !== A_T1H || width_q[24] !== A_T1H || width_q[25] !== A_T0H)
                $display("FAIL boundary_width: slots 22..25 = %0d %0d %0d %0d, want 20 40 40 20", width_q[22], width_q[23], width_q[24], width_q[25]);
            else n_pass++;
            n_checks++;
            if (rise_q[24] - rise_q[23] !== A_TBIT) $display("FAIL boundary_gap: slot 23->24 spacing %0d, want %0d", rise_q[24] - rise_q[23], A_TBIT);
            else n_pass++;
        end
    endtask

    task automatic test_full_frame();
        int bad, i, w, a, last;
        bit b;
        bad = 0;
        i = 0;
        sel = 1'b1;
        for (int p = 0; p < 64; p++) ram_b[p] = 24'($urandom);
        @(negedge clk) drive_start(1'b1);
        push_frame(64);
        capture(15000, 0, 1'b0);
        n_checks++;
        if (width_q.size() !== 1536) $display("FAIL full_pulses: %0d pulses, want 1536", width_q.size());
        else n_pass++;
        while (exp_bits.size() > 0 && width_q.size() > 0) begin
            b = exp_bits.pop_front();
            w = width_q.pop_front();
            n_checks++;
            if (w !== (b ? B_T1H : B_T0H)) $display("FAIL full_bit: bit %0d high %0d cycles, want %0d", i, w, b ? B_T1H : B_T0H);
            else n_pass++;
            i++;
        end
        for (int j = 1; j < rise_q.size(); j++) if (rise_q[j] - rise_q[j-1] != B_TBIT) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL full_period: %0d periods not %0d cycles, want 0", bad, B_TBIT);
        else n_pass++;
        n_checks++;
        if (rda_q.size() !== 64) $display("FAIL full_rd_count: %0d rd pulses, want 64", rda_q.size());
        else n_pass++;
        while (exp_addr.size() > 0 && rda_q.size() > 0) begin
            w = exp_addr.pop_front();
            a = rda_q.pop_front();
            n_checks++;
            if (a !== w) $display("FAIL full_addr: rd at %0d, want %0d", a, w);
            else n_pass++;
        end
        last = rise_q.size() > 0 ? rise_q[rise_q.size()-1] : 0;
        n_checks++;
        if (done_q.size() !== 1 || done_q[0] !== last + B_TBIT + B_TRES)
            $display("FAIL full_latch: %0d done pulses at %0d, want 1 at %0d", done_q.size(), done_q.size() > 0 ? done_q[0] : -1, last + B_TBIT + B_TRES);
        else n_pass++;
    endtask

    initial begin
        for (int p = 0; p < 64; p++) begin
            ram_a[p] = 24'($urandom);
            ram_b[p] = 24'($urandom);
        end
        test_reset();
        test_pattern();
        test_latency();
        test_ignore_start();
        test_back_to_back();
        test_full_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
